// File: rtl/program_loader_pkg.sv
// Shared constants and types for the boot-time program loader.
package program_loader_pkg;

    localparam int LOADER_ADDR_WIDTH = 8;
    localparam int LOADER_DATA_WIDTH = 8;

    // Start-of-frame marker; only recognised between frames.
    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    // Named view of the loader states, for debug and for code outside the loader.
    typedef enum logic [2:0] {
        LOADER_IDLE  = 3'd0,
        LOADER_LEN   = 3'd1,
        LOADER_ADDR  = 3'd2,
        LOADER_DATA  = 3'd3,
        LOADER_CSUM  = 3'd4,
        LOADER_DONE  = 3'd5,
        LOADER_ERROR = 3'd6
    } loader_state_t;

    // Plain constants with the same encodings, used by the RTL state register.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    // A frame is in progress from the length byte up to the checksum byte.
    function automatic logic state_is_busy(input logic [2:0] st);
        return (st == ST_LEN) || (st == ST_ADDR) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write-port bundle between the byte source, the loader and the RAM mux.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Byte source / system side: drives the stream, observes the write port.
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side: consumes the stream, drives the write port.
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses SYNC/LEN/ADDR/DATA.../CSUM frames from a byte stream, writes the
// payload into program RAM and holds the CPU in reset until a frame verifies.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = LOADER_ADDR_WIDTH,
    parameter int DATA_WIDTH     = LOADER_DATA_WIDTH,  // the frame format is byte based; keep at 8
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int BOOT_HOLD      = 1
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    program_loader_if.slave  bus,
    output logic             cpu_reset_o,
    output logic             busy,
    output logic             load_done,
    output logic             load_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Idle count value at which one more silent cycle expires the frame.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [7:0]            sum_q, sum_d;
    logic [8:0]            remain_q, remain_d;     // data bytes still expected (1..256)
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]      idle_q, idle_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic       accept;
    logic [7:0] rx_byte;
    logic [7:0] sum_plus;

    // The loader never back-pressures the source.
    assign bus.rx_ready = 1'b1;
    assign accept       = bus.rx_valid & bus.rx_ready;
    assign rx_byte      = bus.rx_data[7:0];
    assign sum_plus     = sum_q + rx_byte;

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_reset_o   = cpu_rst_q;
    assign busy          = state_is_busy(state_q);
    assign load_done     = done_q;
    assign load_error    = err_q;

    // Frame parser: next state, checksum, pointer, write strobe and status flags.
    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        remain_d  = remain_q;
        ptr_d     = ptr_q;
        idle_d    = idle_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        if (accept) begin
            idle_d = '0;
            case (state_q)
                ST_LEN: begin
                    // A zero length byte encodes a full 256-byte payload.
                    remain_d = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                    sum_d    = sum_plus;
                    state_d  = ST_ADDR;
                end
                ST_ADDR: begin
                    ptr_d   = ADDR_WIDTH'(rx_byte);
                    sum_d   = sum_plus;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    we_d     = 1'b1;
                    addr_d   = ptr_q;
                    wdata_d  = rx_byte;
                    ptr_d    = ptr_q + ADDR_WIDTH'(1);
                    sum_d    = sum_plus;
                    remain_d = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
                        state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (sum_plus == 8'h00) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    // Between frames only the sync byte matters; everything else is noise.
                    if (rx_byte == LOADER_SYNC_BYTE) begin
                        state_d   = ST_LEN;
                        sum_d     = 8'h00;
                        cpu_rst_d = 1'b1;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                    end
                end
            endcase
        end else if (state_is_busy(state_q)) begin
            // A stalled source inside a frame aborts it rather than hanging the boot.
            if (idle_q == TIMEOUT_LAST) begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset aborts any frame and drops a pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            sum_q     <= 8'h00;
            remain_q  <= 9'd0;
            ptr_q     <= '0;
            idle_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            cpu_rst_q <= (BOOT_HOLD != 0);
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            remain_q  <= remain_d;
            ptr_q     <= ptr_d;
            idle_q    <= idle_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule
